piso_serializer: RTL and testbench



---
 rtl/serial_pkg.sv | 28 ++
 rtl/bit_counter.sv | 35 +++
 rtl/piso_serializer.sv | 118 +++++++++++
 tb/tb_piso_serializer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// serial_pkg: constants shared by the serial transmit and receive blocks.
// Holds the FSM state encoding, the default word width and a clog2 helper.
package serial_pkg;

   localparam logic ST_IDLE  = 1'b0;
   localparam logic ST_SHIFT = 1'b1;

   localparam int unsigned DEFAULT_DATA_W = 8;

   typedef enum logic {
      StIdle  = ST_IDLE,
      StShift = ST_SHIFT
   } state_e;

   // Ceiling log2, used at elaboration time to size counters.
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned result;
      int unsigned rem;
      result = 0;
      rem    = value - 1;
      while (rem > 0) begin
         result++;
         rem = rem >> 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/bit_counter.sv
// bit_counter: frame bit counter with synchronous reload, enable and a
// terminal-count flag. Saturates at FRAME_W-1 and only returns to 0 on reload.
module bit_counter
   import serial_pkg::*;
#(
   parameter int unsigned FRAME_W = DEFAULT_DATA_W,
   localparam int unsigned CNT_W  = clog2(FRAME_W)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             en,
   output logic [CNT_W-1:0] count,
   output logic             tc
);

   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(FRAME_W - 1);

   logic [CNT_W-1:0] count_q;

   // Reload starts a new frame at bit 0; enable steps one bit, held at the terminal count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else if (load) begin
         count_q <= '0;
      end else if (en && !tc) begin
         count_q <= count_q + CNT_W'(1);
      end
   end

   assign count = count_q;
   assign tc    = (count_q == MAX_CNT);

endmodule

// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in, serial-out transmitter with valid/ready input
// and registered o_sd/o_sv/o_last outputs, one bit per clock, no gap between
// back-to-back words.
// Build option: define PISO_PARITY_EN to append an even-parity bit to each frame.
module piso_serializer
   import serial_pkg::*;
#(
   parameter int unsigned DATA_W    = DEFAULT_DATA_W,
   parameter bit          MSB_FIRST = 1'b1
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic [DATA_W-1:0] i_data,
   input  logic              i_valid,
   output logic              o_ready,
   output logic              o_sd,
   output logic              o_sv,
   output logic              o_last,
   output logic              o_busy
);

`ifdef PISO_PARITY_EN
   localparam int unsigned FRAME_W = DATA_W + 1;
`else
   localparam int unsigned FRAME_W = DATA_W;
`endif
   localparam int unsigned CNT_W = clog2(FRAME_W);

   state_e            state_q;
   logic [DATA_W-1:0] shreg_q;
   logic [DATA_W-1:0] shreg_adv;
   logic              sd_q;
   logic              sv_q;
   logic              last_q;
`ifdef PISO_PARITY_EN
   logic              parity_q;
`endif

   logic              first_bit;
   logic              adv_bit;
   logic              accept;
   logic              tc;
   logic [CNT_W-1:0]  count;

   // Ready in idle, or on the final bit so the next word follows with no gap.
   assign o_ready = (state_q == StIdle) || ((state_q == StShift) && tc);
   assign accept  = i_valid && o_ready;

   bit_counter #(
      .FRAME_W (FRAME_W)
   ) u_bit_counter (
      .clk   (i_clk),
      .rst_n (i_rst_n),
      .load  (accept),
      .en    (state_q == StShift),
      .count (count),
      .tc    (tc)
   );

   // Bit-order selection: first bit of a new word and the next bit of the current one.
   always_comb begin
      if (MSB_FIRST) begin
         shreg_adv = shreg_q << 1;
         first_bit = i_data[DATA_W-1];
         adv_bit   = shreg_q[DATA_W-2];
      end else begin
         shreg_adv = shreg_q >> 1;
         first_bit = i_data[0];
         adv_bit   = shreg_q[1];
      end
`ifdef PISO_PARITY_EN
      // After the last data bit the held parity goes out.
      if (count == CNT_W'(DATA_W - 1)) begin
         adv_bit = parity_q;
      end
`endif
   end

   // Transmit FSM: load on accept, step one bit per cycle, drop to idle after the last bit.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q  <= StIdle;
         shreg_q  <= '0;
         sd_q     <= 1'b0;
         sv_q     <= 1'b0;
         last_q   <= 1'b0;
`ifdef PISO_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else if (accept) begin
         state_q  <= StShift;
         shreg_q  <= i_data;
         sd_q     <= first_bit;
         sv_q     <= 1'b1;
         last_q   <= 1'b0;
`ifdef PISO_PARITY_EN
         parity_q <= ^i_data;
`endif
      end else if (state_q == StShift) begin
         if (tc) begin
            state_q <= StIdle;
            sd_q    <= 1'b0;
            sv_q    <= 1'b0;
            last_q  <= 1'b0;
         end else begin
            shreg_q <= shreg_adv;
            sd_q    <= adv_bit;
            last_q  <= (count == CNT_W'(FRAME_W - 2));
         end
      end
   end

   assign o_sd   = sd_q;
   assign o_sv   = sv_q;
   assign o_last = last_q;
   assign o_busy = sv_q;

endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: drives an MSB-first and an LSB-first instance with the
// same stimulus and checks both serial lines against a per-bit scoreboard.
// Honours PISO_PARITY_EN when the bundle is built with it.
module tb_piso_serializer;

   localparam int unsigned DATA_W = 8;
`ifdef PISO_PARITY_EN
   localparam int unsigned FRAME_W = DATA_W + 1;
`else
   localparam int unsigned FRAME_W = DATA_W;
`endif

   typedef struct {
      logic [7:0] data;
      logic [7:0] msb_seq;  // bits in time order, first bit in [7]
      logic [7:0] lsb_seq;
      logic       par;
   } vec_t;

   typedef struct {
      logic sd;
      logic last;
   } bit_t;

   logic       clk;
   logic       rst_n;
   logic       valid;
   logic [7:0] data;
   logic       rdy_m, sd_m, sv_m, last_m, busy_m;
   logic       rdy_l, sd_l, sv_l, last_l, busy_l;

   vec_t tbl[9];
   bit_t q_m[$];
   bit_t q_l[$];

   int checks;
   int failures;
   int sv_seen;
   int last_seen;

   piso_serializer #(
      .DATA_W    (DATA_W),
      .MSB_FIRST (1'b1)
   ) dut_m (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_data  (data),
      .i_valid (valid),
      .o_ready (rdy_m),
      .o_sd    (sd_m),
      .o_sv    (sv_m),
      .o_last  (last_m),
      .o_busy  (busy_m)
   );

   piso_serializer #(
      .DATA_W    (DATA_W),
      .MSB_FIRST (1'b0)
   ) dut_l (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_data  (data),
      .i_valid (valid),
      .o_ready (rdy_l),
      .o_sd    (sd_l),
      .o_sv    (sv_l),
      .o_last  (last_l),
      .o_busy  (busy_l)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model ready: idle, or the bit on the line is the last of its frame.
   function automatic logic model_ready();
      if (q_m.size() == 0) return 1'b1;
      return q_m[0].last;
   endfunction

   task automatic push(input int idx);
      for (int i = 0; i < int'(DATA_W); i++) begin
         q_m.push_back('{sd: tbl[idx].msb_seq[DATA_W-1-i], last: (i == int'(FRAME_W) - 1)});
         q_l.push_back('{sd: tbl[idx].lsb_seq[DATA_W-1-i], last: (i == int'(FRAME_W) - 1)});
      end
`ifdef PISO_PARITY_EN
      q_m.push_back('{sd: tbl[idx].par, last: 1'b1});
      q_l.push_back('{sd: tbl[idx].par, last: 1'b1});
`endif
   endtask

   task automatic sample();
      bit_t fm;
      bit_t fl;
      logic er;
      fm = '{sd: 1'b0, last: 1'b0};
      fl = '{sd: 1'b0, last: 1'b0};
      if (q_m.size() > 0) fm = q_m[0];
      if (q_l.size() > 0) fl = q_l[0];
      er = model_ready();
      chk("m_sv", sv_m, q_m.size() > 0);
      chk("l_sv", sv_l, q_l.size() > 0);
      chk("m_busy", busy_m, q_m.size() > 0);
      chk("l_busy", busy_l, q_l.size() > 0);
      chk("m_last", last_m, fm.last);
      chk("l_last", last_l, fl.last);
      chk("m_ready", rdy_m, er);
      chk("l_ready", rdy_l, er);
      if (q_m.size() > 0) chk("m_sd", sd_m, fm.sd);
      if (q_l.size() > 0) chk("l_sd", sd_l, fl.sd);
      if (sv_m) sv_seen++;
      if (last_m) last_seen++;
   endtask

   // One clock: drive inputs, retire the displayed bit, queue an accepted word, check.
   task automatic step(input logic v, input logic [7:0] d, input int idx);
      logic acc;
      valid = v;
      data  = d;
      acc   = v && model_ready();
      @(posedge clk);
      if (q_m.size() > 0) void'(q_m.pop_front());
      if (q_l.size() > 0) void'(q_l.pop_front());
      if (acc) push(idx);
      #1;
      sample();
   endtask

   task automatic chk_cleared(input string tag);
      chk({tag, "_m_sv"}, sv_m, 1'b0);
      chk({tag, "_m_sd"}, sd_m, 1'b0);
      chk({tag, "_m_last"}, last_m, 1'b0);
      chk({tag, "_m_busy"}, busy_m, 1'b0);
      chk({tag, "_l_sv"}, sv_l, 1'b0);
      chk({tag, "_l_sd"}, sd_l, 1'b0);
      chk({tag, "_l_last"}, last_l, 1'b0);
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      tbl[0] = '{data: 8'hA5, msb_seq: 8'hA5, lsb_seq: 8'hA5, par: 1'b0};
      tbl[1] = '{data: 8'h3C, msb_seq: 8'h3C, lsb_seq: 8'h3C, par: 1'b0};
      tbl[2] = '{data: 8'h01, msb_seq: 8'h01, lsb_seq: 8'h80, par: 1'b1};
      tbl[3] = '{data: 8'hC8, msb_seq: 8'hC8, lsb_seq: 8'h13, par: 1'b1};
      tbl[4] = '{data: 8'h96, msb_seq: 8'h96, lsb_seq: 8'h69, par: 1'b0};
      tbl[5] = '{data: 8'hFF, msb_seq: 8'hFF, lsb_seq: 8'hFF, par: 1'b0};
      tbl[6] = '{data: 8'h00, msb_seq: 8'h00, lsb_seq: 8'h00, par: 1'b0};
      tbl[7] = '{data: 8'h07, msb_seq: 8'h07, lsb_seq: 8'hE0, par: 1'b1};
      tbl[8] = '{data: 8'h03, msb_seq: 8'h03, lsb_seq: 8'hC0, par: 1'b0};

      // Reset held 3 cycles with valid high: nothing captured, outputs low.
      rst_n = 1'b0;
      valid = 1'b1;
      data  = 8'hFF;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         chk_cleared("rst");
      end
      valid = 1'b0;
      rst_n = 1'b1;
      chk("rst_m_ready", rdy_m, 1'b1);
      chk("rst_l_ready", rdy_l, 1'b1);
      step(1'b0, 8'h5A, 0);
      step(1'b0, 8'hC3, 0);

      // Table: one frame per word; a 0xFF offered in the 3rd bit cycle must be ignored.
      for (int k = 0; k < 9; k++) begin
         sv_seen   = 0;
         last_seen = 0;
         step(1'b1, tbl[k].data, k);
         for (int j = 1; j < int'(FRAME_W); j++) begin
            if (j == 2) step(1'b1, 8'hFF, 5);
            else        step(1'b0, 8'($urandom), 0);
         end
         step(1'b0, 8'($urandom), 0);
         chk("tbl_sv_cycles", sv_seen, FRAME_W);
         chk("tbl_last_pulses", last_seen, 1);
      end

      // Back-to-back: 0xA5 then 0x3C with valid held, no gap between frames.
      sv_seen   = 0;
      last_seen = 0;
      step(1'b1, 8'hA5, 0);
      for (int j = 0; j < int'(FRAME_W); j++) step(1'b1, 8'h3C, 1);
      for (int j = 0; j < int'(FRAME_W); j++) step(1'b0, 8'($urandom), 0);
      chk("b2b_sv_cycles", sv_seen, 2 * FRAME_W);
      chk("b2b_last_pulses", last_seen, 2);

      // Reset on the 4th bit of 0xA5: outputs clear without a clock edge.
      step(1'b1, 8'hA5, 0);
      for (int j = 0; j < 3; j++) step(1'b0, 8'($urandom), 0);
      chk("pre_rst_sv", sv_m, 1'b1);
      rst_n = 1'b0;
      #1;
      chk_cleared("async");
      chk("async_m_ready", rdy_m, 1'b1);
      q_m.delete();
      q_l.delete();
      @(posedge clk);
      #1;
      chk_cleared("async_hold");
      rst_n = 1'b1;

      // Fresh frame after reset: 0xFF, full length with a single last pulse.
      sv_seen   = 0;
      last_seen = 0;
      step(1'b1, 8'hFF, 5);
      for (int j = 1; j < int'(FRAME_W); j++) step(1'b0, 8'($urandom), 0);
      step(1'b0, 8'h00, 0);
      chk("post_rst_sv_cycles", sv_seen, FRAME_W);
      chk("post_rst_last_pulses", last_seen, 1);
      chk("queue_drained", q_m.size() + q_l.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
